// File: rtl/systolic_mm_stream.sv
// Output-stationary ROWS x COLS systolic matrix multiplier: streams A columns / B rows,
// accumulates in place, then drains rounded and saturated result rows one per handshake.
module systolic_mm_rnd #(
   parameter int AW = 32,
   parameter int DW = 16,
   parameter int SH = 6
) (
   input  logic [AW-1:0] i_acc,
   output logic [DW-1:0] o_val,
   output logic          o_sat
);
   logic signed [AW-1:0] w_sh;
   logic signed [AW-1:0] w_rnd;

   assign w_sh  = $signed(i_acc) >>> SH;
   assign w_rnd = w_sh + AW'(i_acc[SH-1]);
   assign o_sat = (w_rnd[AW-1:DW-1] != {(AW-DW+1){w_rnd[AW-1]}});

   always_comb begin
      o_val = w_rnd[DW-1:0];
      if (o_sat) o_val = w_rnd[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   end
endmodule

module systolic_mm_stream #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int DATA_FRAC    = 10,
   parameter int WEIGHT_WIDTH = 8,
   parameter int WEIGHT_FRAC  = 6,
   parameter int ACCUM_WIDTH  = 32,
   parameter int MAX_K        = 256,
   parameter int K_W          = $clog2(MAX_K+1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [K_W-1:0]               k_len,
   input  logic                         acc_mode,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH*ROWS-1:0]   a_col,
   input  logic [WEIGHT_WIDTH*COLS-1:0] b_row,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH*COLS-1:0]   out_row,
   output logic [$clog2(ROWS)-1:0]      out_row_idx,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done,
   output logic                         sat_any
);
   localparam int RW = $clog2(ROWS);
   localparam int FC_W = $clog2(ROWS+COLS);
   localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
   // Products carry DATA_FRAC+WEIGHT_FRAC fraction bits; results keep DATA_FRAC.
   localparam int SH = DATA_FRAC + WEIGHT_FRAC - DATA_FRAC;
   localparam logic [K_W-1:0]  KMAX = K_W'(MAX_K);
   localparam logic [FC_W-1:0] FL_LAST = FC_W'(ROWS+COLS-2);
   localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS-1);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

   state_t                r_state, w_next;
   logic [K_W-1:0]        r_k, r_cnt, w_klen;
   logic [FC_W-1:0]       r_fcnt;
   logic [RW-1:0]         r_row;
   logic                  r_done, r_sat;
   logic                  w_beat, w_clr;

   logic [ROWS-1:0][DATA_WIDTH-1:0]               w_ask;
   logic [ROWS-1:0]                               w_askv;
   logic [COLS-1:0][WEIGHT_WIDTH-1:0]             w_bsk;
   logic [COLS-1:0]                               w_bskv;
   logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]     w_pa;
   logic [ROWS-1:0][COLS-1:0][WEIGHT_WIDTH-1:0]   w_pb;
   logic [ROWS-1:0][COLS-1:0]                     w_pav, w_pbv;
   logic [ROWS-1:0][COLS-2:0][DATA_WIDTH-1:0]     r_a;
   logic [ROWS-1:0][COLS-2:0]                     r_av;
   logic [ROWS-2:0][COLS-1:0][WEIGHT_WIDTH-1:0]   r_b;
   logic [ROWS-2:0][COLS-1:0]                     r_bv;
   logic [ROWS-1:0][COLS-1:0][ACCUM_WIDTH-1:0]    r_acc;
   logic [COLS-1:0][ACCUM_WIDTH-1:0]              w_sel;
   logic [COLS-1:0][DATA_WIDTH-1:0]               w_rowv;
   logic [COLS-1:0]                               w_sat;

   function automatic logic [ACCUM_WIDTH-1:0] f_prod(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [WEIGHT_WIDTH-1:0] b);
      logic [PW-1:0] p;
      p = {{WEIGHT_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[WEIGHT_WIDTH-1]}}, b};
      return {{(ACCUM_WIDTH-PW){p[PW-1]}}, p};
   endfunction

   assign w_klen = (k_len > KMAX) ? KMAX : k_len;
   assign w_beat = in_valid & in_ready;
   assign w_clr  = (r_state == IDLE) & start & ~acc_mode;

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE:  if (start) w_next = (w_klen == '0) ? FLUSH : LOAD;
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (r_cnt == r_k - K_W'(1))) w_next = FLUSH;
         end
         FLUSH: if (r_fcnt == FL_LAST) w_next = DRAIN;
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (r_row == ROW_LAST)) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_cnt   <= '0;
         r_fcnt  <= '0;
         r_row   <= '0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == DRAIN) && out_ready && (r_row == ROW_LAST);
         case (r_state)
            IDLE: if (start) begin
               r_k    <= w_klen;
               r_cnt  <= '0;
               r_fcnt <= '0;
               r_row  <= '0;
               r_sat  <= 1'b0;
            end
            LOAD:  if (in_valid) r_cnt <= r_cnt + K_W'(1);
            FLUSH: r_fcnt <= r_fcnt + FC_W'(1);
            DRAIN: begin
               r_sat <= r_sat | (|w_sat);
               if (out_ready) r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end
            default: ;
         endcase
      end
   end

   // Input skew: lane i of A waits i cycles, lane j of B waits j cycles.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
      if (gi == 0) begin : g_d0
         assign w_ask[gi]  = a_col[gi*DATA_WIDTH +: DATA_WIDTH];
         assign w_askv[gi] = w_beat;
      end else begin : g_dn
         logic [gi-1:0][DATA_WIDTH-1:0] r_d;
         logic [gi-1:0]                 r_v;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_d <= '0;
               r_v <= '0;
            end else begin
               r_d[0] <= a_col[gi*DATA_WIDTH +: DATA_WIDTH];
               r_v[0] <= w_beat;
               for (int k = 1; k < gi; k++) begin
                  r_d[k] <= r_d[k-1];
                  r_v[k] <= r_v[k-1];
               end
            end
         end
         assign w_ask[gi]  = r_d[gi-1];
         assign w_askv[gi] = r_v[gi-1];
      end
   end

   for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
      if (gj == 0) begin : g_d0
         assign w_bsk[gj]  = b_row[gj*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         assign w_bskv[gj] = w_beat;
      end else begin : g_dn
         logic [gj-1:0][WEIGHT_WIDTH-1:0] r_d;
         logic [gj-1:0]                   r_v;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_d <= '0;
               r_v <= '0;
            end else begin
               r_d[0] <= b_row[gj*WEIGHT_WIDTH +: WEIGHT_WIDTH];
               r_v[0] <= w_beat;
               for (int k = 1; k < gj; k++) begin
                  r_d[k] <= r_d[k-1];
                  r_v[k] <= r_v[k-1];
               end
            end
         end
         assign w_bsk[gj]  = r_d[gj-1];
         assign w_bskv[gj] = r_v[gj-1];
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
         if (gj == 0) begin : g_al
            assign w_pa[gi][gj]  = w_ask[gi];
            assign w_pav[gi][gj] = w_askv[gi];
         end else begin : g_ai
            assign w_pa[gi][gj]  = r_a[gi][gj-1];
            assign w_pav[gi][gj] = r_av[gi][gj-1];
         end
         if (gi == 0) begin : g_bt
            assign w_pb[gi][gj]  = w_bsk[gj];
            assign w_pbv[gi][gj] = w_bskv[gj];
         end else begin : g_bi
            assign w_pb[gi][gj]  = r_b[gi-1][gj];
            assign w_pbv[gi][gj] = r_bv[gi-1][gj];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a  <= '0;
         r_av <= '0;
         r_b  <= '0;
         r_bv <= '0;
      end else begin
         for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS-1; j++) begin
               r_a[i][j]  <= w_pa[i][j];
               r_av[i][j] <= w_pav[i][j];
            end
         for (int i = 0; i < ROWS-1; i++)
            for (int j = 0; j < COLS; j++) begin
               r_b[i][j]  <= w_pb[i][j];
               r_bv[i][j] <= w_pbv[i][j];
            end
      end
   end

   // Bubbles travel as cleared tags, so only paired valid operands touch an accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else if (w_clr) r_acc <= '0;
      else begin
         for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
               if (w_pav[i][j] && w_pbv[i][j])
                  r_acc[i][j] <= r_acc[i][j] + f_prod(w_pa[i][j], w_pb[i][j]);
      end
   end

   assign w_sel = r_acc[r_row];

   for (genvar gj = 0; gj < COLS; gj++) begin : g_rnd
      systolic_mm_rnd #(.AW(ACCUM_WIDTH), .DW(DATA_WIDTH), .SH(SH)) u_rnd (
         .i_acc (w_sel[gj]),
         .o_val (w_rowv[gj]),
         .o_sat (w_sat[gj])
      );
   end

   assign out_row     = (r_state == DRAIN) ? w_rowv : '0;
   assign out_row_idx = (r_state == DRAIN) ? r_row : '0;
   assign out_last    = (r_state == DRAIN) && (r_row == ROW_LAST);
   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign sat_any     = r_sat;
endmodule

// File: tb/tb_systolic_mm_stream.sv
// Directed bench for systolic_mm_stream at 4x4: identity, accumulate, bubbles/stall,
// lane mapping, saturation/rounding, k_len clamp, mid-job reset and empty jobs.
module tb_systolic_mm_stream;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int KW = 9;

   logic            clk, rst_n, start, acc_mode, in_valid, in_ready;
   logic            out_valid, out_ready, out_last, busy, done, sat_any;
   logic [KW-1:0]   k_len;
   logic [16*R-1:0] a_col;
   logic [8*C-1:0]  b_row;
   logic [16*C-1:0] out_row;
   logic [1:0]      out_row_idx;

   int    n_assert = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    t_start;
   string cur = "init";

   logic [63:0] a_beats  [4];
   logic [31:0] b_beats  [4];
   logic [63:0] exp_rows [4];

   systolic_mm_stream #(.ROWS(R), .COLS(C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_mode(acc_mode),
      .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done),
      .sat_any(sat_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0h expected %0h", cur, tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {58'd0, in_ready, out_valid, out_last, busy, done, sat_any}, 64'd0);
      chk({tag, "_row"}, out_row, 64'd0);
      chk({tag, "_idx"}, {62'd0, out_row_idx}, 64'd0);
   endtask

   task automatic set_uniform(input logic [15:0] a, input logic [7:0] b, input logic [15:0] r);
      for (int i = 0; i < 4; i++) begin
         a_beats[i]  = {4{a}};
         b_beats[i]  = {4{b}};
         exp_rows[i] = {4{r}};
      end
   endtask

   task automatic set_identity(input logic [15:0] r);
      for (int i = 0; i < 4; i++) begin
         a_beats[i] = 64'd0;
         a_beats[i][i*16 +: 16] = 16'h0400;
         b_beats[i]  = 32'h4040_4040;
         exp_rows[i] = {4{r}};
      end
   endtask

   task automatic run_job(input int k, input logic mode, input bit bubbles, input bit stall,
                          input bit sdrain, input logic exp_sat);
      int kk;
      int n;
      kk = (k > 256) ? 256 : k;
      @(posedge clk); #1;
      start = 1'b1; k_len = KW'(k); acc_mode = mode; t_start = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_run", {63'd0, busy}, 64'd1);
      chk("sat_clr", {63'd0, sat_any}, 64'd0);
      if (kk > 0) chk("in_ready_load", {63'd0, in_ready}, 64'd1);
      for (int b = 0; b < kk; b++) begin
         in_valid = 1'b1; a_col = a_beats[b % 4]; b_row = b_beats[b % 4];
         @(posedge clk); #1;
         if (bubbles) begin
            in_valid = 1'b0; a_col = '1; b_row = '1;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      chk("in_ready_flush", {63'd0, in_ready}, 64'd0);
      n = 0;
      while (!out_valid && n < 2000) begin @(posedge clk); #1; n++; end
      chk("ov_timeout", {63'd0, out_valid}, 64'd1);
      if (!bubbles) chk("latency", 64'(cyc - t_start), 64'(1 + kk + R + C - 1));
      for (int r = 0; r < 4; r++) begin
         n = 0;
         while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
         chk("row_idx", {62'd0, out_row_idx}, 64'(r));
         chk("row_val", out_row, exp_rows[r]);
         chk("row_last", {63'd0, out_last}, (r == 3) ? 64'd1 : 64'd0);
         if (stall && r == 1) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
               chk("stall_idx", {62'd0, out_row_idx}, 64'd1);
               chk("stall_row", out_row, exp_rows[1]);
               chk("stall_valid", {63'd0, out_valid}, 64'd1);
            end
            out_ready = 1'b1;
         end
         if (sdrain && r == 2) begin start = 1'b1; k_len = KW'(2); acc_mode = 1'b0; end
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk("busy_end", {63'd0, busy}, 64'd0);
      chk("ov_end", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("done_clear", {63'd0, done}, 64'd0);
      chk("sat_any", {63'd0, sat_any}, {63'd0, exp_sat});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 1'b0; k_len = '0; acc_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a_col = '0; b_row = '0; rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_zero("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      cur = "identity";   set_identity(16'h0400);  run_job(4, 1'b0, 0, 0, 0, 1'b0);
      cur = "accumulate"; set_identity(16'h0800);  run_job(4, 1'b1, 0, 0, 0, 1'b0);
      cur = "bubbles";    set_identity(16'h0400);  run_job(4, 1'b0, 1, 1, 0, 1'b0);

      cur = "lanes";
      a_beats[0]  = 64'h1000_0C00_0800_0400;
      b_beats[0]  = 32'h1020_C040;
      exp_rows[0] = 64'h0100_0200_FC00_0400;
      exp_rows[1] = 64'h0200_0400_F800_0800;
      exp_rows[2] = 64'h0300_0600_F400_0C00;
      exp_rows[3] = 64'h0400_0800_F000_1000;
      run_job(1, 1'b0, 0, 0, 1, 1'b0);

      cur = "sat_pos";  set_uniform(16'h7FFF, 8'h7F, 16'h7FFF); run_job(4, 1'b0, 0, 0, 0, 1'b1);
      cur = "sat_neg";  set_uniform(16'h8000, 8'h7F, 16'h8000); run_job(4, 1'b0, 0, 0, 0, 1'b1);
      cur = "rnd_up";   set_uniform(16'h0001, 8'h20, 16'h0001); run_job(1, 1'b0, 0, 0, 0, 1'b0);
      cur = "rnd_down"; set_uniform(16'h0001, 8'h1F, 16'h0000); run_job(1, 1'b0, 0, 0, 0, 1'b0);
      cur = "rnd_neg";  set_uniform(16'hFFFF, 8'h20, 16'h0000); run_job(1, 1'b0, 0, 0, 0, 1'b0);
      cur = "clamp";    set_uniform(16'h0004, 8'h01, 16'h0010); run_job(300, 1'b0, 0, 0, 0, 1'b0);

      cur = "reset_mid";
      set_identity(16'h0400);
      @(posedge clk); #1;
      start = 1'b1; k_len = KW'(4); acc_mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; a_col = a_beats[b]; b_row = b_beats[b];
         @(posedge clk); #1;
      end
      chk("busy_pre_rst", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_async");
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cur = "after_reset"; run_job(4, 1'b1, 0, 0, 0, 1'b0);

      cur = "k_zero"; set_uniform(16'h1234, 8'h11, 16'h0000); run_job(0, 1'b0, 0, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/systolic_mm_stream.md
SYSTOLIC_MM_STREAM -- requirements
Module: systolic_mm_stream

Interface
REQ-001 SHALL have parameters: ROWS, 8, PE rows / A-vector lanes; COLS, 8, PE columns / B-vector lanes; DATA_WIDTH, 16, S5.10 data width; DATA_FRAC, 10; WEIGHT_WIDTH, 8, S1.6 weight width; WEIGHT_FRAC, 6; ACCUM_WIDTH, 32, accumulator width; MAX_K, 256, max reduction depth; K_W, clog2(MAX_K+1).
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request, sampled in IDLE only.
- k_len  in  K_W  reduction depth, sampled with start.
- acc_mode  in  1  0 = clear accumulators at start; 1 = add onto previous tile.
- in_valid / in_ready  in / out  1  input beat handshake.
- a_col  in  DATA_WIDTH*ROWS  A[:,k], lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_row  in  WEIGHT_WIDTH*COLS  B[k,:], lane j likewise.
- out_valid / out_ready  out / in  1  output row handshake.
- out_row  out  DATA_WIDTH*COLS  result row, S5.10.
- out_row_idx  out  clog2(ROWS)  index of out_row.
- out_last  out  1  high with row ROWS-1.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at job end.
- sat_any  out  1  sticky: any element of the current job saturated.

Function
REQ-003 SHALL use FSM states IDLE, LOAD, FLUSH, DRAIN.
REQ-004 IDLE, start=1: capture k_len/acc_mode; if acc_mode=0 zero all accumulators; clear sat_any; go to LOAD (k_len>0) or FLUSH (k_len=0).
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 in_ready SHALL be 1 only in LOAD; a beat transfers when in_valid and in_ready are both 1.
REQ-007 After k_len accepted beats, LOAD SHALL go to FLUSH; no further beats accepted.
REQ-008 Array SHALL be output-stationary systolic: lane i of A delayed i cycles into row i, lane j of B delayed j cycles into column j; operands and a valid tag pass right/down one PE per cycle.
REQ-009 PE(i,j) SHALL accumulate a*b only when both arriving tags are 1; input bubbles (in_valid=0) propagate as invalid tags and SHALL NOT alter results.
REQ-010 Product SHALL be signed DATA_WIDTH x WEIGHT_WIDTH, sign-extended into ACCUM_WIDTH (DATA_FRAC+WEIGHT_FRAC frac bits); accumulation wraps modulo 2^ACCUM_WIDTH.
REQ-011 FLUSH SHALL last exactly ROWS+COLS-1 cycles, then go to DRAIN.
REQ-012 Output element = (acc >>> WEIGHT_FRAC) + acc[WEIGHT_FRAC-1] (round half up), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; any saturation sets sat_any.
REQ-013 DRAIN SHALL present rows 0..ROWS-1 in order with out_valid=1; row advances on out_valid&out_ready; out_row/out_row_idx/out_last held stable while stalled.
REQ-014 On the handshake of row ROWS-1: go to IDLE; done=1 next cycle for one cycle; busy=0 same cycle as done.
REQ-015 Accumulators SHALL retain values in IDLE for acc_mode=1 reuse.
REQ-016 Minimum start-to-first-out_valid latency SHALL be 1 + k_len + ROWS + COLS - 1 cycles with no bubbles.
REQ-017 k_len > MAX_K SHALL be clamped to MAX_K.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, zero accumulators, pipeline regs and valid tags, and drive in_ready, out_valid, out_last, busy, done, sat_any, out_row, out_row_idx to 0.
REQ-019 Reset mid-job SHALL abandon the job; first job after release SHALL behave as from power-up.

Verification (ROWS=COLS=4)
REQ-020 Identity: acc_mode=0, k_len=4, A=I (diag 1024), B all 64 -> every out element 1024 (0x0400), sat_any=0, first out_valid 12 cycles after start.
REQ-021 Saturation/rounding: A all 0x7FFF, B all 0x7F, k_len=4 -> all 0x7FFF, sat_any=1; A=0x8000, B=0x7F -> all 0x8000; k_len=1, A=1, B=32 -> 1; A=1, B=31 -> 0; A=-1, B=32 -> 0.
REQ-022 Bubbles/backpressure: REQ-020 stimulus with in_valid toggling each cycle and out_ready low 5 cycles at row 1 -> identical results; out_row_idx held at 1 and out_row stable during stall.
REQ-023 Accumulate: REQ-020 job then same inputs with acc_mode=1 -> all elements 2048.
REQ-024 Reset/edge: rst_n low for 1 cycle after 2 LOAD beats -> all outputs 0 immediately; next REQ-020 job correct; k_len=0, acc_mode=0 -> four rows of zeros; start during DRAIN ignored.
